// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester and mem_system signal bundle for mem_arbiter
interface mem_arbiter_if;
   logic        i_rd;
   logic [15:0] i_addr;
   logic        i_done;
   logic [15:0] i_data;
   logic        i_hit;
   logic        i_stall;
   logic        i_err;

   logic        d_rd;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_done;
   logic [15:0] d_data;
   logic        d_hit;
   logic        d_stall;
   logic        d_err;

   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_dataout;
   logic        mem_done;
   logic        mem_hit;
   logic        mem_err;

   modport slave (
      input  i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata,
      input  mem_dataout, mem_done, mem_hit, mem_err,
      output i_done, i_data, i_hit, i_stall, i_err,
      output d_done, d_data, d_hit, d_stall, d_err,
      output mem_addr, mem_wdata, mem_rd, mem_wr
   );

   modport master (
      output i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata,
      output mem_dataout, mem_done, mem_hit, mem_err,
      input  i_done, i_data, i_hit, i_stall, i_err,
      input  d_done, d_data, d_hit, d_stall, d_err,
      input  mem_addr, mem_wdata, mem_rd, mem_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one mem_system between fetch (I) and data (D) requesters
// D has priority; a starvation counter forces an I grant, a watchdog aborts hung accesses.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;
   localparam logic [1:0] ERR_D = 2'd3;

   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int WDOG_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_LIMIT);
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

   logic [1:0]        state;
   logic [CNT_W-1:0]  starveCnt;
   logic [WDOG_W-1:0] wdogCnt;

   logic dPend, dIllegal, inGrant, expired, finish;
   logic iFin, dFin, errFin;
   logic [15:0] rspData;
   logic rspHit, rspErr;

   assign dPend    = bus.d_rd | bus.d_wr;
   assign dIllegal = bus.d_rd & bus.d_wr;
   assign inGrant  = (state == GNT_I) || (state == GNT_D);
   assign expired  = inGrant & ~bus.mem_done & (wdogCnt == WDOG_MAX);
   assign finish   = inGrant & (bus.mem_done | expired);

   // A real mem_done wins over a watchdog expiry landing in the same cycle.
   assign rspData = bus.mem_done ? bus.mem_dataout : 16'h0;
   assign rspHit  = bus.mem_done & bus.mem_hit;
   assign rspErr  = bus.mem_done ? bus.mem_err : 1'b1;

   assign iFin   = (state == GNT_I) & finish;
   assign dFin   = (state == GNT_D) & finish;
   assign errFin = (state == ERR_D);

   assign bus.i_done  = iFin;
   assign bus.i_data  = iFin ? rspData : 16'h0;
   assign bus.i_hit   = iFin & rspHit;
   assign bus.i_err   = iFin & rspErr;
   assign bus.i_stall = rst_n & bus.i_rd & ~iFin;

   assign bus.d_done  = dFin | errFin;
   assign bus.d_data  = dFin ? rspData : 16'h0;
   assign bus.d_hit   = dFin & rspHit;
   assign bus.d_err   = errFin | (dFin & rspErr);
   assign bus.d_stall = rst_n & dPend & ~(dFin | errFin);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         starveCnt     <= '0;
         wdogCnt       <= '0;
         bus.mem_addr  <= 16'h0;
         bus.mem_wdata <= 16'h0;
         bus.mem_rd    <= 1'b0;
         bus.mem_wr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wdogCnt <= '0;
               if (dIllegal) begin
                  state <= ERR_D;
               end else if (dPend && (!bus.i_rd || starveCnt < CNT_MAX)) begin
                  state         <= GNT_D;
                  bus.mem_addr  <= bus.d_addr;
                  bus.mem_wdata <= bus.d_wdata;
                  bus.mem_rd    <= bus.d_rd;
                  bus.mem_wr    <= bus.d_wr;
                  if (bus.i_rd && starveCnt != CNT_MAX)
                     starveCnt <= starveCnt + 1'b1;
               end else if (bus.i_rd) begin
                  state         <= GNT_I;
                  bus.mem_addr  <= bus.i_addr;
                  bus.mem_wdata <= 16'h0;
                  bus.mem_rd    <= 1'b1;
                  bus.mem_wr    <= 1'b0;
                  starveCnt     <= '0;
               end
            end
            GNT_I, GNT_D: begin
               if (finish) begin
                  state      <= IDLE;
                  bus.mem_rd <= 1'b0;
                  bus.mem_wr <= 1'b0;
                  wdogCnt    <= '0;
               end else begin
                  wdogCnt <= wdogCnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT      = 64;
   localparam int NEVER        = 255;

   typedef struct {
      int          kind;   // 0 read, 1 write, 2 illegal rd+wr (D only)
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          lat;    // grant cycle index on which memory answers
      logic        hit;
      logic        merr;
      int          gap;    // idle cycles before the requester's next request
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus();
   mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int   checks, errors, cyc;
   txn_t iQ[$], dQ[$];
   int   gnt, waitCnt, starve, iGap, dGap;
   logic iReq, dRd, dWr, iReqPrev, prevMemReq;
   int   iStartCyc, memRiseCyc;
   int   doneLog[$], iLatLog[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic txn_t mk(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] rdata, input int lat, input int gap);
      txn_t t;
      t.kind = kind; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
      t.lat = lat; t.gap = gap; t.hit = 1'($urandom); t.merr = 1'b0;
      return t;
   endfunction

   // Requesters present queue heads; memory answers the granted head after its latency.
   task automatic drive();
      txn_t t;
      iReq = (iQ.size() > 0) && (iGap == 0);
      dRd = 1'b0; dWr = 1'b0;
      if (dQ.size() > 0 && dGap == 0) begin
         dRd = (dQ[0].kind != 1);
         dWr = (dQ[0].kind != 0);
      end
      if (iReq && !iReqPrev) iStartCyc = cyc;
      iReqPrev = iReq;
      bus.i_rd    = iReq;
      bus.i_addr  = iReq ? iQ[0].addr : 16'($urandom);
      bus.d_rd    = dRd;
      bus.d_wr    = dWr;
      bus.d_addr  = (dRd | dWr) ? dQ[0].addr : 16'($urandom);
      bus.d_wdata = (dRd | dWr) ? dQ[0].wdata : 16'($urandom);
      bus.mem_done    = 1'b0;
      bus.mem_dataout = 16'($urandom);
      bus.mem_hit     = 1'($urandom);
      bus.mem_err     = 1'($urandom);
      if (gnt == 1 || gnt == 2) begin
         t = (gnt == 1) ? iQ[0] : dQ[0];
         if (waitCnt == t.lat) begin
            bus.mem_done = 1'b1; bus.mem_dataout = t.rdata;
            bus.mem_hit = t.hit; bus.mem_err = t.merr;
         end
      end else if (gnt == 0 && $urandom_range(3) == 0) begin
         bus.mem_done = 1'b1;
      end
   endtask

   task automatic checkCycle();
      txn_t t;
      logic [18:0] expI, expD, resp;
      bit fin;
      expI = '0; expD = '0; resp = '0; fin = 0;
      if (gnt == 1 || gnt == 2) begin
         t = (gnt == 1) ? iQ[0] : dQ[0];
         chk("mem_rd", 32'(bus.mem_rd), 32'(gnt == 1 || t.kind == 0));
         chk("mem_wr", 32'(bus.mem_wr), 32'(gnt == 2 && t.kind == 1));
         chk("mem_addr", 32'(bus.mem_addr), 32'(t.addr));
         if (gnt == 2 && t.kind == 1) chk("mem_wdata", 32'(bus.mem_wdata), 32'(t.wdata));
         if (waitCnt == t.lat) begin
            fin = 1; resp = {1'b1, t.hit, t.merr, t.rdata};
         end else if (waitCnt == TIMEOUT - 1) begin
            fin = 1; resp = {1'b1, 1'b0, 1'b1, 16'h0};
         end
         if (gnt == 1) expI = resp; else expD = resp;
      end else begin
         chk("mem_idle", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
         if (gnt == 3) begin
            fin = 1; expD = {1'b1, 1'b0, 1'b1, 16'h0};
         end
      end
      chk("i_resp", 32'({bus.i_done, bus.i_hit, bus.i_err, bus.i_data}), 32'(expI));
      chk("d_resp", 32'({bus.d_done, bus.d_hit, bus.d_err, bus.d_data}), 32'(expD));
      chk("i_stall", 32'(bus.i_stall), 32'(iReq & ~expI[18]));
      chk("d_stall", 32'(bus.d_stall), 32'((dRd | dWr) & ~expD[18]));

      if ((bus.mem_rd | bus.mem_wr) && !prevMemReq) memRiseCyc = cyc;
      prevMemReq = bus.mem_rd | bus.mem_wr;
      if (bus.i_done) begin doneLog.push_back(1); iLatLog.push_back(cyc - iStartCyc); end
      if (bus.d_done) doneLog.push_back(2);

      if (fin) begin
         if (gnt == 1) begin iGap = iQ[0].gap; void'(iQ.pop_front()); iReqPrev = 1'b0; end
         else begin dGap = dQ[0].gap; void'(dQ.pop_front()); end
         gnt = 0; waitCnt = 0;
      end else if (gnt != 0) begin
         waitCnt++;
      end else if (dRd && dWr) begin
         gnt = 3;
      end else if ((dRd | dWr) && (!iReq || starve < STARVE_LIMIT)) begin
         gnt = 2;
         if (iReq) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
      end else if (iReq) begin
         gnt = 1; starve = 0;
      end
      if (!iReq && iGap > 0) iGap--;
      if (!(dRd | dWr) && dGap > 0) dGap--;
      cyc++;
   endtask

   task automatic oneCycle();
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      checkCycle();
   endtask

   task automatic runUntilIdle(input int budget);
      int n = 0;
      while ((iQ.size() > 0 || dQ.size() > 0 || gnt != 0) && n < budget) begin
         oneCycle();
         n++;
      end
      chk("drain", 32'(iQ.size() + dQ.size() + gnt), 32'd0);
   endtask

   task automatic doReset(input bit expectWr);
      @(posedge clk); #1;
      if (expectWr) chk("pre_rst_mem_wr", 32'(bus.mem_wr), 32'd1);
      rst_n = 1'b0;
      bus.i_rd = 1'b1;
      #1;
      chk("rst_mem", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
      chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'd0);
      chk("rst_flags", 32'({bus.i_done, bus.i_hit, bus.i_err, bus.i_stall,
                            bus.d_done, bus.d_hit, bus.d_err, bus.d_stall}), 32'd0);
      chk("rst_data", {bus.i_data, bus.d_data}, 32'd0);
      iQ.delete(); dQ.delete();
      gnt = 0; waitCnt = 0; starve = 0; iGap = 0; dGap = 0;
      iReq = 1'b0; dRd = 1'b0; dWr = 1'b0; iReqPrev = 1'b0; prevMemReq = 1'b0;
      bus.i_rd = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.mem_done = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      doneLog.delete(); iLatLog.delete();
   endtask

   initial begin
      int expS[8];
      txn_t t;
      checks = 0; errors = 0; cyc = 0; iStartCyc = 0; memRiseCyc = 0;
      bus.i_rd = 1'b0; bus.i_addr = 16'h0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
      bus.d_addr = 16'h0; bus.d_wdata = 16'h0; bus.mem_dataout = 16'h0;
      bus.mem_done = 1'b0; bus.mem_hit = 1'b0; bus.mem_err = 1'b0;
      doReset(1'b0);

      // fetch only
      iQ.push_back(mk(0, 16'h0010, 16'h0, 16'hBEEF, 3, 0));
      runUntilIdle(200);
      chk("fetch_dones", 32'(doneLog.size()), 32'd1);
      chk("fetch_port", 32'(at(doneLog, 0)), 32'd1);
      chk("fetch_mem_delay", 32'(memRiseCyc - iStartCyc), 32'd1);
      chk("fetch_latency", 32'(at(iLatLog, 0)), 32'd4);

      // simultaneous I read and D write: D first
      doReset(1'b0);
      iQ.push_back(mk(0, 16'h0040, 16'h0, 16'hCAFE, 2, 0));
      dQ.push_back(mk(1, 16'h0020, 16'h1234, 16'h0, 2, 0));
      runUntilIdle(200);
      chk("simul_first", 32'(at(doneLog, 0)), 32'd2);
      chk("simul_second", 32'(at(doneLog, 1)), 32'd1);

      // starvation: four D grants, then I, then D resumes
      doReset(1'b0);
      for (int k = 0; k < 6; k++) dQ.push_back(mk(1, 16'(16'h0100 + k), 16'($urandom), 16'h0, 1, 0));
      for (int k = 0; k < 2; k++) iQ.push_back(mk(0, 16'(16'h0200 + k), 16'h0, 16'($urandom), 1, 0));
      runUntilIdle(400);
      expS = '{2, 2, 2, 2, 1, 2, 2, 1};
      chk("starve_count", 32'(doneLog.size()), 32'd8);
      for (int k = 0; k < 8; k++) chk($sformatf("starve_order%0d", k), 32'(at(doneLog, k)), 32'(expS[k]));

      // illegal D request, then a normal D read
      doReset(1'b0);
      dQ.push_back(mk(2, 16'h0300, 16'h0, 16'h0, 0, 0));
      dQ.push_back(mk(0, 16'h0302, 16'h0, 16'h7777, 1, 0));
      runUntilIdle(200);
      chk("illegal_dones", 32'(doneLog.size()), 32'd2);

      // timeout then a normal fetch
      doReset(1'b0);
      iQ.push_back(mk(0, 16'h0400, 16'h0, 16'h0, NEVER, 0));
      iQ.push_back(mk(0, 16'h0402, 16'h0, 16'h4242, 1, 0));
      runUntilIdle(400);
      chk("timeout_latency", 32'(at(iLatLog, 0)), 32'd64);
      chk("after_timeout_latency", 32'(at(iLatLog, 1)), 32'd2);

      // reset during GNT_D
      doReset(1'b0);
      dQ.push_back(mk(1, 16'h8055, 16'h5AA5, 16'h0, NEVER, 0));
      repeat (3) oneCycle();
      doReset(1'b1);
      repeat (4) oneCycle();
      chk("post_rst_dones", 32'(doneLog.size()), 32'd0);
      dQ.push_back(mk(0, 16'h0500, 16'h0, 16'h1357, 2, 0));
      iQ.push_back(mk(0, 16'h0600, 16'h0, 16'h2468, 0, 0));
      runUntilIdle(200);

      // randomized traffic
      doReset(1'b0);
      for (int k = 0; k < 40; k++) begin
         t = mk(0, 16'($urandom), 16'h0, 16'($urandom),
                ($urandom_range(24) == 0) ? NEVER : $urandom_range(4), $urandom_range(3));
         t.merr = ($urandom_range(7) == 0);
         iQ.push_back(t);
         t = mk(($urandom_range(15) == 0) ? 2 : $urandom_range(1), 16'($urandom), 16'($urandom),
                16'($urandom), ($urandom_range(24) == 0) ? NEVER : $urandom_range(4), $urandom_range(3));
         t.merr = ($urandom_range(7) == 0);
         dQ.push_back(t);
      end
      runUntilIdle(8000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one mem_system instance (unified cache plus four-bank memory) between the instruction-fetch requester (port I) and the data-memory requester (port D).
- Picks one requester and registers its request. Drives the mem_system Addr/DataIn/Rd/Wr and holds them stable until Done. Returns Done, DataOut, CacheHit and err to the granted requester only.
- D has priority over I. A starvation counter guarantees I forward progress.
- Sits between the fetch/memory pipeline stages and mem_system.

Parameters:
- STARVE_LIMIT, default 4: number of consecutive D grants made while I is pending; once reached, I wins the next arbitration.
- TIMEOUT, default 64: maximum cycles spent in a grant state without mem_done before the transaction is aborted with an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_rd  in  1  fetch read request; held high until i_done
- i_addr  in  16  fetch address
- i_done  out  1  one-cycle completion pulse for I
- i_data  out  16  read data, valid when i_done
- i_hit  out  1  CacheHit of the completed I access, valid when i_done
- i_stall  out  1  I request pending and not completing this cycle
- i_err  out  1  error flag, valid when i_done
- d_rd  in  1  data read request; held until d_done
- d_wr  in  1  data write request; held until d_done
- d_addr  in  16  data address
- d_wdata  in  16  write data
- d_done  out  1  one-cycle completion pulse for D
- d_data  out  16  read data, valid when d_done
- d_hit  out  1  CacheHit of the completed D access, valid when d_done
- d_stall  out  1  D request pending and not completing this cycle
- d_err  out  1  error flag, valid when d_done
- mem_addr  out  16  to mem_system Addr
- mem_wdata  out  16  to mem_system DataIn
- mem_rd  out  1  to mem_system Rd
- mem_wr  out  1  to mem_system Wr
- mem_dataout  in  16  from mem_system DataOut
- mem_done  in  1  from mem_system Done
- mem_hit  in  1  from mem_system CacheHit
- mem_err  in  1  from mem_system err

Behaviour:
- States: IDLE, GNT_I, GNT_D, ERR_D.

Reset:
- On rst_n low, asynchronously enter IDLE.
- Reset values: mem_rd=mem_wr=0, mem_addr=mem_wdata=0, starvation count=0, watchdog=0.
- All requester outputs are 0 while reset is asserted.
- Reset mid-transaction drops mem_rd/mem_wr immediately. mem_system is reset by its own reset; the arbiter does not sequence it.

Arbitration in IDLE, evaluated every cycle:
- Illegal D request (d_rd & d_wr) → go to ERR_D. The request is not forwarded to memory.
- Else if D is pending and (I is idle or count < STARVE_LIMIT) → go to GNT_D. If i_rd was high, count increments, saturating at STARVE_LIMIT.
- Else if i_rd → go to GNT_I; count clears to 0.
- On entering a grant state, the winner's addr/wdata/rd/wr are registered into mem_addr/mem_wdata/mem_rd/mem_wr. Memory sees the request on the cycle after the arbitration decision.

GNT_x:
- Memory outputs are held constant.
- The watchdog increments each cycle.
- When mem_done=1:
  - x_done=1 and x_data=mem_dataout, combinationally in the same cycle.
  - x_hit=mem_hit; x_err=mem_err.
  - mem_rd/mem_wr clear and the state returns to IDLE.
- If the watchdog reaches TIMEOUT-1 without mem_done:
  - x_done=1, x_err=1, x_data=0.
  - Return to IDLE; the watchdog clears.

ERR_D:
- Lasts one cycle: d_done=1, d_err=1, d_data=0.
- Return to IDLE; count is unchanged.

Timing and stalls:
- Minimum turnaround: 1 arbitration cycle, then N cycles to mem_done, then 1 IDLE cycle before the next grant. There is no back-to-back grant in the same cycle as done.
- x_stall = request pending & ~x_done.
- x_done, x_data, x_hit and x_err are 0 whenever x_done is 0.

Input handling:
- A requester dropping its request while granted is a protocol violation. The arbiter ignores it and completes the transaction.
- mem_done arriving while in IDLE is ignored.

Test Plan:
- Fetch only: i_rd=1, i_addr=16'h0010, memory returns 16'hBEEF after 3 cycles → mem_rd rises 1 cycle after i_rd; i_done pulses once with i_data=16'hBEEF; d_done stays 0.
- Simultaneous requests: i_rd=1 and d_wr=1 (addr 16'h0020, data 16'h1234) in the same cycle → D granted first with mem_wr=1 and mem_wdata=16'h1234; after d_done, I is granted; i_done follows.
- Starvation with STARVE_LIMIT=4: D requests continuously while I holds i_rd → exactly 4 D grants, then the 5th grant goes to I; count clears and D resumes after.
- Illegal D request: d_rd=1 and d_wr=1 → mem_rd=mem_wr=0 throughout; d_done=1 and d_err=1 one cycle later.
- Timeout with TIMEOUT=64: memory never asserts done → i_done=1 with i_err=1 exactly 64 cycles after the grant; the next request is served normally.
- Reset mid-transaction: assert rst_n=0 during GNT_D → mem_wr=0 within the same cycle (asynchronous); after release, state is IDLE and no d_done is emitted.
